// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } seq_tx_state_t;

    // Default pattern: the sequence the downstream 1101 detector looks for.
    localparam logic [3:0] SEQ_DEF_PATTERN = 4'b1101;

endpackage : seq_pkg

// File: rtl/seq_down_cnt.sv
// Loadable down counter that saturates at zero and never wraps.
module seq_down_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] value_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign value_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule : seq_down_cnt

// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: sends a WIDTH-bit pattern MSB-first,
// repeat_cnt times, with an optional idle gap between frames.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int unsigned     WIDTH       = 4,
    parameter logic [WIDTH-1:0] DEF_PATTERN = WIDTH'(SEQ_DEF_PATTERN),
    parameter int unsigned     CNT_W       = 8,
    parameter int unsigned     GAP_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             use_def,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    output logic             out,
    output logic             out_valid,
    output logic             frame_end,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     BIT_W    = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    seq_tx_state_t    state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [WIDTH-1:0] pat_sel;

    logic             out_q, out_valid_q, frame_end_q, busy_q, done_q;
    logic             out_d, out_valid_d, frame_end_d, busy_d, done_d;

    logic             bit_load, bit_en, bit_zero;
    logic [BIT_W-1:0] bit_val, bit_nxt;
    logic             frm_load, frm_en, frm_zero;
    logic [CNT_W-1:0] frm_val;
    logic             gap_load, gap_en, gap_zero;
    logic [GAP_W-1:0] gap_val;

    assign pat_sel = use_def ? DEF_PATTERN : pattern;

    seq_down_cnt #(.W(BIT_W)) u_bit_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (bit_load),
        .en_i       (bit_en),
        .load_val_i (BIT_LAST),
        .value_o    (bit_val),
        .zero_o     (bit_zero)
    );

    seq_down_cnt #(.W(CNT_W)) u_frm_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (frm_load),
        .en_i       (frm_en),
        .load_val_i (repeat_cnt),
        .value_o    (frm_val),
        .zero_o     (frm_zero)
    );

    seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (gap_load),
        .en_i       (gap_en),
        .load_val_i (gap_len_q - 1'b1),
        .value_o    (gap_val),
        .zero_o     (gap_zero)
    );

    // Next-state, datapath and counter control.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        pat_d     = pat_q;
        gap_len_d = gap_len_q;
        bit_load  = 1'b0;
        bit_en    = 1'b0;
        frm_load  = 1'b0;
        frm_en    = 1'b0;
        gap_load  = 1'b0;
        gap_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (repeat_cnt != '0)) begin
                    pat_d     = pat_sel;
                    sreg_d    = pat_sel;
                    gap_len_d = gap;
                    bit_load  = 1'b1;
                    frm_load  = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // A zero frame count cannot legitimately be shifting.
                if (abort || frm_zero) begin
                    state_d = IDLE;
                end else if (bit_zero) begin
                    frm_en = 1'b1;
                    if (frm_val == CNT_W'(1)) begin
                        state_d = FIN;
                    end else if (gap_len_q != '0) begin
                        gap_load = 1'b1;
                        state_d  = GAP;
                    end else begin
                        sreg_d   = pat_q;
                        bit_load = 1'b1;
                    end
                end else begin
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    bit_en = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_zero) begin
                    sreg_d   = pat_q;
                    bit_load = 1'b1;
                    state_d  = SHIFT;
                end else begin
                    gap_en = (gap_val != '0);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from next-state values so they leave straight from flops.
    always_comb begin
        bit_nxt     = bit_load ? BIT_LAST : (bit_en ? bit_val - 1'b1 : bit_val);
        out_d       = (state_d == SHIFT) && sreg_d[WIDTH-1];
        out_valid_d = (state_d == SHIFT);
        frame_end_d = (state_d == SHIFT) && (bit_nxt == '0);
        busy_d      = (state_d == SHIFT) || (state_d == GAP);
        done_d      = (state_d == FIN);
    end

    // State, pattern and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            pat_q       <= '0;
            gap_len_q   <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            frame_end_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            pat_q       <= pat_d;
            gap_len_q   <= gap_len_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            frame_end_q <= frame_end_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign frame_end = frame_end_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : seq_pattern_tx

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus pushes expected per-cycle
// output records, a negedge monitor pops and compares whenever the DUT is active.
module tb_seq_pattern_tx;

    localparam logic [3:0] DEF = 4'b1101;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       use_def;
    logic [3:0] pattern;
    logic [7:0] repeat_cnt;
    logic [3:0] gap;
    logic       out;
    logic       out_valid;
    logic       frame_end;
    logic       busy;
    logic       done;

    seq_pattern_tx #(
        .WIDTH (4),
        .CNT_W (8),
        .GAP_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .use_def    (use_def),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap        (gap),
        .out        (out),
        .out_valid  (out_valid),
        .frame_end  (frame_end),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int   cyc;
        logic o;
        logic v;
        logic fe;
        logic b;
        logic d;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bench-side overlapping 1101 detector fed by the valid serial stream.
    logic       det_clr;
    logic [3:0] hist;
    int         nbits;
    int         hits;
    always @(negedge clk) begin
        if (det_clr) begin
            hist  <= '0;
            nbits <= 0;
            hits  <= 0;
        end else if (out_valid) begin
            hist  <= {hist[2:0], out};
            nbits <= nbits + 1;
            if (nbits >= 3 && {hist[2:0], out} == 4'b1101) hits <= hits + 1;
        end
    end

    // Monitor: every active DUT cycle must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (out || out_valid || frame_end || busy || done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_activity cyc=%0d actual out=%b v=%b fe=%b busy=%b done=%b required=idle",
                         cyc, out, out_valid, frame_end, busy, done);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || out !== e.o || out_valid !== e.v || frame_end !== e.fe ||
                    busy !== e.b || done !== e.d) begin
                    errors++;
                    $display("FAIL stream actual cyc=%0d out=%b v=%b fe=%b busy=%b done=%b required cyc=%0d out=%b v=%b fe=%b busy=%b done=%b",
                             cyc, out, out_valid, frame_end, busy, done, e.cyc, e.o, e.v, e.fe, e.b, e.d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int c, input logic o, input logic v, input logic fe, input logic b, input logic d);
        exp_t e;
        e.cyc = c; e.o = o; e.v = v; e.fe = fe; e.b = b; e.d = d;
        q.push_back(e);
    endtask

    // Expected response of a burst whose start is presented in cycle c0;
    // limit > 0 truncates the burst after that many active cycles (abort / reset).
    task automatic push_burst(input logic [3:0] pat, input int rc, input int gp, input int c0, input int limit);
        int t = c0 + 1;
        int n = 0;
        if (rc == 0) return;
        for (int f = 0; f < rc; f++) begin
            for (int b = 0; b < 4; b++) begin
                if (limit > 0 && n >= limit) return;
                push(t, pat[3-b], 1'b1, (b == 3), 1'b1, 1'b0);
                t++; n++;
            end
            if (f != rc - 1) begin
                for (int g = 0; g < gp; g++) begin
                    if (limit > 0 && n >= limit) return;
                    push(t, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                    t++; n++;
                end
            end
        end
        if (limit > 0 && n >= limit) return;
        push(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic issue(input logic [3:0] pat, input logic ud, input int rc, input int gp,
                         input int limit, output int c0);
        @(negedge clk);
        c0 = cyc;
        push_burst(ud ? DEF : pat, rc, gp, c0, limit);
        pattern    = pat;
        use_def    = ud;
        repeat_cnt = 8'(rc);
        gap        = 4'(gp);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int c0;
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        use_def    = 1'b0;
        pattern    = '0;
        repeat_cnt = '0;
        gap        = '0;
        det_clr    = 1'b1;

        // 1: reset held with clocks running, then idle after release
        repeat (3) @(negedge clk);
        check("reset_outputs", {27'd0, out, out_valid, frame_end, busy, done}, 32'd0);
        @(negedge clk);
        check("reset_outputs_hold", {27'd0, out, out_valid, frame_end, busy, done}, 32'd0);
        reset   = 1'b1;
        det_clr = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_reset", {27'd0, out, out_valid, frame_end, busy, done}, 32'd0);

        // 2: default pattern, single frame
        issue(4'b0000, 1'b1, 1, 0, 0, c0);
        wait_until(c0 + 7);
        check("t2_drain", q.size(), 0);

        // 3: user pattern 1011, three frames with 2-cycle gaps
        issue(4'b1011, 1'b0, 3, 2, 0, c0);
        wait_until(c0 + 19);
        check("t3_drain", q.size(), 0);

        // 4: back-to-back default frames into the detector; start while busy ignored
        det_clr = 1'b1;
        repeat (2) @(negedge clk);
        det_clr = 1'b0;
        issue(4'b0000, 1'b1, 2, 0, 0, c0);
        wait_until(c0 + 3);
        pattern    = 4'b0000;
        use_def    = 1'b0;
        repeat_cnt = 8'd5;
        gap        = 4'd3;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        wait_until(c0 + 12);
        check("t4_detector_hits", hits, 2);
        check("t4_drain", q.size(), 0);

        // 5: abort on the 2nd bit of frame 2, then a fresh full burst
        issue(4'b0110, 1'b0, 4, 1, 7, c0);
        wait_until(c0 + 7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_busy_after_abort", {31'd0, busy}, 32'd0);
        check("t5_valid_after_abort", {31'd0, out_valid}, 32'd0);
        repeat (4) @(negedge clk);
        check("t5_abort_drain", q.size(), 0);
        issue(4'b1110, 1'b0, 2, 1, 0, c0);
        wait_until(c0 + 12);
        check("t5_drain", q.size(), 0);

        // 6: zero repeat count ignored; async reset mid-SHIFT
        @(negedge clk);
        repeat_cnt = 8'd0;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_zero_count_busy", {31'd0, busy}, 32'd0);
        issue(4'b0000, 1'b1, 3, 0, 2, c0);
        wait_until(c0 + 2);
        @(posedge clk);
        #1;
        check("t6_busy_before_reset", {31'd0, busy}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("t6_reset_outputs", {27'd0, out, out_valid, frame_end, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_idle_after_reset", {27'd0, out, out_valid, frame_end, busy, done}, 32'd0);
        issue(4'b1000, 1'b0, 1, 0, 0, c0);
        wait_until(c0 + 7);

        check("final_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_pattern_tx
